fetch_pc_unit: RTL

Program-counter and fetch-sequencing stage that sits directly upstream of the instruction memory. It drives the word address into instruction memory and tracks which PC the registered memory output belongs to. It applies branch redirects with a one-slot squash, stalls, and halt. Downstream decode/control consumes instr_valid and instr_pc alongside the memory's instr output.

---
 rtl/fetch_pc_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_unit
// Purpose  : PC generation and fetch sequencing ahead of a 1-cycle registered
//            instruction memory: branch redirect with one-slot squash, stall,
//            and sticky halt.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_unit #(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int OFFSET_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [OFFSET_W-1:0] branch_offset,
    input  logic                halt_req,
    output logic [31:0]         fetch_addr,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    output logic                halted,
    output logic [31:0]         retired_count
);

    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam int                c_ext_w    = (OFFSET_W > ADDR_W) ? OFFSET_W : ADDR_W;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                instr_valid_q, instr_valid_d;
    logic [31:0]         retired_count_q, retired_count_d;

    logic                w_accept;
    logic [c_ext_w-1:0]  w_offset_ext;
    logic [ADDR_W-1:0]   w_branch_target;

    assign w_accept        = instr_valid_q && !stall && (state_q == ST_RUN);
    assign w_offset_ext    = c_ext_w'(signed'(branch_offset));
    // Target is relative to the slot after the branch; truncation gives the wrap.
    assign w_branch_target = instr_pc_q + ADDR_W'(1) + w_offset_ext[ADDR_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ST_RUN;
            pc_q            <= c_reset_pc;
            instr_pc_q      <= '0;
            instr_valid_q   <= 1'b0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            instr_pc_q      <= instr_pc_d;
            instr_valid_q   <= instr_valid_d;
            retired_count_q <= retired_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        instr_pc_d      = instr_pc_q;
        instr_valid_d   = instr_valid_q;
        retired_count_d = retired_count_q;

        if (state_q == ST_HALTED) begin
            instr_valid_d = 1'b0;
        end else if (w_accept && halt_req) begin
            state_d         = ST_HALTED;
            instr_valid_d   = 1'b0;
            retired_count_d = retired_count_q + 32'd1;
        end else if (stall && instr_valid_q) begin
            instr_valid_d = instr_valid_q;
        end else if (w_accept && branch_taken) begin
            // The sequential fetch already in flight is squashed.
            pc_d            = w_branch_target;
            instr_valid_d   = 1'b0;
            retired_count_d = retired_count_q + 32'd1;
        end else begin
            instr_pc_d    = pc_q;
            pc_d          = pc_q + ADDR_W'(1);
            instr_valid_d = 1'b1;
            if (w_accept) begin
                retired_count_d = retired_count_q + 32'd1;
            end
        end
    end

    // On a stall the memory re-reads the held instruction's address.
    assign fetch_addr    = (stall && instr_valid_q && (state_q == ST_RUN)) ?
                           32'(instr_pc_q) : 32'(pc_q);
    assign instr_pc      = instr_pc_q;
    assign instr_valid   = instr_valid_q;
    assign halted        = (state_q == ST_HALTED);
    assign retired_count = retired_count_q;

endmodule
`default_nettype wire
